rf_writeback: RTL and testbench



---
 rtl/rf_wb_pkg.sv | 43 ++++
 rtl/rf_wb_fifo.sv | 68 ++++++
 rtl/rf_writeback.sv | 141 ++++++++++++++
 tb/tb_rf_writeback.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/rf_wb_pkg.sv
// Shared widths, load encodings and the write-back entry type for rf_writeback.
package rf_wb_pkg;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned REG_AW = 5;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  typedef struct packed {
    logic [REG_AW-1:0] rd;
    logic [XLEN-1:0]   data;
  } wb_entry_t;

  // Byte/halfword selection and extension of a returned load word.
  function automatic logic [XLEN-1:0] load_extract(input logic [2:0]      funct3,
                                                   input logic [1:0]      addr_lo,
                                                   input logic [XLEN-1:0] rdata);
    logic [7:0]  b;
    logic [15:0] h;
    logic [XLEN-1:0] res;
    case (addr_lo)
      2'd0:    b = rdata[7:0];
      2'd1:    b = rdata[15:8];
      2'd2:    b = rdata[23:16];
      default: b = rdata[31:24];
    endcase
    h = addr_lo[1] ? rdata[31:16] : rdata[15:0];
    case (funct3)
      F3_LB:   res = {{(XLEN-8){b[7]}}, b};
      F3_LH:   res = {{(XLEN-16){h[15]}}, h};
      F3_LW:   res = rdata;
      F3_LBU:  res = {{(XLEN-8){1'b0}}, b};
      F3_LHU:  res = {{(XLEN-16){1'b0}}, h};
      default: res = '0;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/rf_wb_fifo.sv
// ALU result buffer holding {rd, data}; per-entry rd/valid exposed for the hazard scoreboard.
module rf_wb_fifo
  import rf_wb_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          push,
  input  wb_entry_t                     push_entry,
  input  logic                          pop,
  output wb_entry_t                     head,
  output logic                          full,
  output logic                          empty,
  output logic [DEPTH-1:0][REG_AW-1:0]  ent_rd,
  output logic [DEPTH-1:0]              ent_vld
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  wb_entry_t [DEPTH-1:0] mem_q, mem_d;
  logic [DEPTH-1:0]      vld_q, vld_d;
  logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]         rd_ptr_q, rd_ptr_d;

  assign full    = &vld_q;
  assign empty   = ~|vld_q;
  assign head    = mem_q[rd_ptr_q];
  assign ent_vld = vld_q;

  always_comb begin
    for (int i = 0; i < int'(DEPTH); i++) ent_rd[i] = mem_q[i].rd;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_comb begin
    mem_d    = mem_q;
    vld_d    = vld_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (pop && !empty) begin
      vld_d[rd_ptr_q] = 1'b0;
      rd_ptr_d        = rd_ptr_q + PW'(1);
    end
    if (push && !full) begin
      mem_d[wr_ptr_q] = push_entry;
      vld_d[wr_ptr_q] = 1'b1;
      wr_ptr_d        = wr_ptr_q + PW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      vld_q    <= vld_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/rf_writeback.sv
// Register-file write-back sequencer: merges ALU results and load returns, tracks pending rds.
// Optional RF_WB_ALU_BYPASS_EN: ALU result skips the FIFO when it is empty and no load completes.
module rf_writeback
  import rf_wb_pkg::*;
#(
  parameter int unsigned ALU_FIFO_DEPTH = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                alu_valid,
  output logic                alu_ready,
  input  logic [REG_AW-1:0]   alu_rd,
  input  logic [XLEN-1:0]     alu_data,
  input  logic                ld_issue,
  output logic                ld_ready,
  input  logic [REG_AW-1:0]   ld_rd,
  input  logic [2:0]          ld_funct3,
  input  logic [1:0]          ld_addr_lo,
  input  logic                mem_rvalid,
  input  logic [XLEN-1:0]     mem_rdata,
  input  logic [REG_AW-1:0]   rs1,
  input  logic [REG_AW-1:0]   rs2,
  output logic                hazard,
  output logic                WrEn_RF,
  output logic [REG_AW-1:0]   WAddr_RF,
  output logic [XLEN-1:0]     WD_RF
);

  logic                ld_pend_q, ld_pend_d;
  logic [REG_AW-1:0]   ld_rd_q, ld_rd_d;
  logic [2:0]          ld_f3_q, ld_f3_d;
  logic [1:0]          ld_lo_q, ld_lo_d;
  logic                wr_en_q, wr_en_d;
  logic [REG_AW-1:0]   waddr_q, waddr_d;
  logic [XLEN-1:0]     wdata_q, wdata_d;

  logic                              fifo_push, fifo_pop, fifo_full, fifo_empty;
  wb_entry_t                         alu_entry, fifo_head;
  logic [ALU_FIFO_DEPTH-1:0][REG_AW-1:0] fifo_rd;
  logic [ALU_FIFO_DEPTH-1:0]         fifo_vld;
  logic                              alu_fire, ld_done, bypass;
  logic                              hit_rs1, hit_rs2;

  assign alu_ready = ~fifo_full;
  assign ld_ready  = ~ld_pend_q;
  assign alu_fire  = alu_valid & ~fifo_full;
  assign ld_done   = ld_pend_q & mem_rvalid;
  assign alu_entry = {alu_rd, alu_data};

  rf_wb_fifo #(.DEPTH(ALU_FIFO_DEPTH)) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push       (fifo_push),
    .push_entry (alu_entry),
    .pop        (fifo_pop),
    .head       (fifo_head),
    .full       (fifo_full),
    .empty      (fifo_empty),
    .ent_rd     (fifo_rd),
    .ent_vld    (fifo_vld)
  );

  // Load capture plus write arbitration: a completing load beats the FIFO head.
  always_comb begin
    ld_pend_d = ld_pend_q;
    ld_rd_d   = ld_rd_q;
    ld_f3_d   = ld_f3_q;
    ld_lo_d   = ld_lo_q;
    wr_en_d   = 1'b0;
    waddr_d   = waddr_q;
    wdata_d   = wdata_q;
    fifo_pop  = 1'b0;
    bypass    = 1'b0;

    if (ld_issue && !ld_pend_q) begin
      ld_pend_d = 1'b1;
      ld_rd_d   = ld_rd;
      ld_f3_d   = ld_funct3;
      ld_lo_d   = ld_addr_lo;
    end

    if (ld_done) begin
      ld_pend_d = 1'b0;
      wr_en_d   = (ld_rd_q != '0);
      waddr_d   = ld_rd_q;
      wdata_d   = load_extract(ld_f3_q, ld_lo_q, mem_rdata);
    end else if (!fifo_empty) begin
      fifo_pop  = 1'b1;
      wr_en_d   = 1'b1;
      waddr_d   = fifo_head.rd;
      wdata_d   = fifo_head.data;
    end
`ifdef RF_WB_ALU_BYPASS_EN
    else if (alu_fire) begin
      bypass    = 1'b1;
      wr_en_d   = (alu_rd != '0);
      waddr_d   = alu_rd;
      wdata_d   = alu_data;
    end
`endif

    // rd = 0 results are accepted but never stored.
    fifo_push = alu_fire && (alu_rd != '0) && !bypass;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ld_pend_q <= 1'b0;
      ld_rd_q   <= '0;
      ld_f3_q   <= '0;
      ld_lo_q   <= '0;
      wr_en_q   <= 1'b0;
      waddr_q   <= '0;
      wdata_q   <= '0;
    end else begin
      ld_pend_q <= ld_pend_d;
      ld_rd_q   <= ld_rd_d;
      ld_f3_q   <= ld_f3_d;
      ld_lo_q   <= ld_lo_d;
      wr_en_q   <= wr_en_d;
      waddr_q   <= waddr_d;
      wdata_q   <= wdata_d;
    end
  end

  // Pending rds: outstanding load, live FIFO entries, and the write in flight.
  always_comb begin
    hit_rs1 = (ld_pend_q && (ld_rd_q == rs1)) || (wr_en_q && (waddr_q == rs1));
    hit_rs2 = (ld_pend_q && (ld_rd_q == rs2)) || (wr_en_q && (waddr_q == rs2));
    for (int i = 0; i < int'(ALU_FIFO_DEPTH); i++) begin
      hit_rs1 = hit_rs1 || (fifo_vld[i] && (fifo_rd[i] == rs1));
      hit_rs2 = hit_rs2 || (fifo_vld[i] && (fifo_rd[i] == rs2));
    end
  end

  assign hazard   = ((rs1 != '0) && hit_rs1) || ((rs2 != '0) && hit_rs2);
  assign WrEn_RF  = wr_en_q;
  assign WAddr_RF = waddr_q;
  assign WD_RF    = wdata_q;

endmodule

// File: tb/tb_rf_writeback.sv
// Randomized scoreboard bench for rf_writeback; honours RF_WB_ALU_BYPASS_EN like the design.
module tb_rf_writeback;

  localparam int unsigned DEPTH = 2;
`ifdef RF_WB_ALU_BYPASS_EN
  localparam int ALU_LAT = 1;
`else
  localparam int ALU_LAT = 2;
`endif

  logic        clk, rst;
  logic        alu_valid, alu_ready;
  logic [4:0]  alu_rd;
  logic [31:0] alu_data;
  logic        ld_issue, ld_ready;
  logic [4:0]  ld_rd;
  logic [2:0]  ld_funct3;
  logic [1:0]  ld_addr_lo;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic [4:0]  rs1, rs2;
  logic        hazard;
  logic        WrEn_RF;
  logic [4:0]  WAddr_RF;
  logic [31:0] WD_RF;

  rf_writeback #(.ALU_FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_data(alu_data),
    .ld_issue(ld_issue), .ld_ready(ld_ready), .ld_rd(ld_rd), .ld_funct3(ld_funct3),
    .ld_addr_lo(ld_addr_lo), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .rs1(rs1), .rs2(rs2), .hazard(hazard),
    .WrEn_RF(WrEn_RF), .WAddr_RF(WAddr_RF), .WD_RF(WD_RF)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct { logic [4:0] rd; logic [31:0] data; int due; } exp_t;
  typedef struct { logic [4:0] rd; logic [31:0] data; } alu_t;

  exp_t        exp_q[$];
  alu_t        mq[$];
  bit          m_ld_pend, m_out_vld, m_ok;
  logic [4:0]  m_ld_rd, m_out_rd;
  logic [2:0]  m_ld_f3;
  logic [1:0]  m_ld_lo;
  int          cyc, errors, checks, last_wr_cyc;
  logic [31:0] last_wd;
  logic [4:0]  wr_log[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [1:0] lo,
                                           input logic [31:0] w);
    logic [31:0] b, h;
    b = (w >> (8 * lo)) & 32'hFF;
    h = (w >> (16 * lo[1])) & 32'hFFFF;
    case (f3)
      3'b000:  return (b > 32'd127) ? (b | 32'hFFFF_FF00) : b;
      3'b001:  return (h > 32'd32767) ? (h | 32'hFFFF_0000) : h;
      3'b010:  return w;
      3'b100:  return b;
      3'b101:  return h;
      default: return 32'd0;
    endcase
  endfunction

  function automatic bit busy(input logic [4:0] r);
    if (r == 5'd0) return 1'b0;
    if (m_ld_pend && m_ld_rd == r) return 1'b1;
    if (m_out_vld && m_out_rd == r) return 1'b1;
    foreach (mq[i]) if (mq[i].rd == r) return 1'b1;
    return 1'b0;
  endfunction

  function automatic void push_exp(input logic [4:0] rd, input logic [31:0] data);
    exp_t e;
    e.rd = rd; e.data = data; e.due = cyc + 1;
    exp_q.push_back(e);
    m_out_vld = 1'b1;
    m_out_rd  = rd;
  endfunction

  // One clock: drive, check handshakes/hazard against the model, then advance the model.
  task automatic step(input bit r, input bit av, input logic [4:0] ard, input logic [31:0] adat,
                      input bit li, input logic [4:0] lrd, input logic [2:0] lf3,
                      input logic [1:0] llo, input bit mv, input logic [31:0] md,
                      input logic [4:0] s1, input logic [4:0] s2);
    bit   exp_ar, exp_lr, exp_hz, acc, byp, collide;
    alu_t a;
    @(negedge clk);
    rst = r; alu_valid = av; alu_rd = ard; alu_data = adat;
    ld_issue = li; ld_rd = lrd; ld_funct3 = lf3; ld_addr_lo = llo;
    mem_rvalid = mv; mem_rdata = md; rs1 = s1; rs2 = s2;
    #1;
    exp_ar = (mq.size() < DEPTH);
    exp_lr = !m_ld_pend;
    exp_hz = busy(s1) || busy(s2);
    if (m_ok) begin
      chk("alu_ready", 32'(alu_ready), 32'(exp_ar));
      chk("ld_ready", 32'(ld_ready), 32'(exp_lr));
      chk("hazard", 32'(hazard), 32'(exp_hz));
    end
    acc = av && exp_ar;
    byp = 1'b0;
    m_out_vld = 1'b0;
    if (r) begin
      mq.delete();
      m_ld_pend = 1'b0;
      m_ok = 1'b1;
    end else begin
      if (m_ld_pend && mv) begin
        collide = 1'b0;
        foreach (mq[i]) if (m_ld_rd != 5'd0 && mq[i].rd == m_ld_rd) collide = 1'b1;
        assert (!collide) else $error("load completion collides with an older queued ALU rd %0d", m_ld_rd);
        if (m_ld_rd != 5'd0) push_exp(m_ld_rd, ref_load(m_ld_f3, m_ld_lo, md));
        m_ld_pend = 1'b0;
      end else if (mq.size() > 0) begin
        a = mq.pop_front();
        push_exp(a.rd, a.data);
      end
`ifdef RF_WB_ALU_BYPASS_EN
      else if (acc) begin
        byp = 1'b1;
        if (ard != 5'd0) push_exp(ard, adat);
      end
`endif
      if (acc && !byp && ard != 5'd0) begin
        a.rd = ard; a.data = adat;
        mq.push_back(a);
      end
      if (li && exp_lr) begin
        m_ld_pend = 1'b1; m_ld_rd = lrd; m_ld_f3 = lf3; m_ld_lo = llo;
      end
    end
    @(posedge clk);
    cyc++;
  endtask

  task automatic idle(input int n, input logic [4:0] s1);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0, s1, 0);
  endtask

  task automatic reset_checks();
    #2;
    chk("rst_wren", 32'(WrEn_RF), 0);
    chk("rst_waddr", 32'(WAddr_RF), 0);
    chk("rst_wd", WD_RF, 0);
    chk("rst_alu_ready", 32'(alu_ready), 1);
    chk("rst_ld_ready", 32'(ld_ready), 1);
    chk("rst_hazard", 32'(hazard), 0);
  endtask

  // Monitor: every write the DUT presents is matched against the scoreboard queue.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (m_ok) begin
      if (WrEn_RF === 1'b1) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_write: addr %0d data %h, none expected (cycle %0d)", WAddr_RF, WD_RF, cyc);
        end else begin
          e = exp_q.pop_front();
          chk("wr_addr", 32'(WAddr_RF), 32'(e.rd));
          chk("wr_data", WD_RF, e.data);
          chk("wr_cycle", cyc, e.due);
        end
        wr_log.push_back(WAddr_RF);
        last_wd = WD_RF;
        last_wr_cyc = cyc;
      end else if (WrEn_RF !== 1'b0) begin
        checks++; errors++;
        $display("FAIL wren_unknown: got %b expected 0/1 (cycle %0d)", WrEn_RF, cyc);
      end else if (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
        e = exp_q.pop_front();
        checks++; errors++;
        $display("FAIL missing_write: got none expected rd %0d data %h due %0d (cycle %0d)", e.rd, e.data, e.due, cyc);
      end
    end
  end

  initial begin
    int n;
    logic [4:0] exp_order[3];
    cyc = 0; errors = 0; checks = 0; m_ok = 1'b0; last_wr_cyc = 0; last_wd = '0;
    m_ld_pend = 1'b0; m_out_vld = 1'b0; m_ld_rd = '0; m_out_rd = '0; m_ld_f3 = '0; m_ld_lo = '0;

    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    reset_checks();

    // Plain ALU write latency.
    n = cyc;
    step(0, 1, 5'd5, 32'h1234_5678, 0, 0, 0, 0, 0, 0, 5'd5, 0);
    idle(3, 5'd5);
    chk("alu_latency", last_wr_cyc - n, ALU_LAT);
    chk("alu_wd", last_wd, 32'h1234_5678);

    // LB and LHU extraction.
    step(0, 0, 0, 0, 1, 5'd7, 3'b000, 2'd3, 0, 0, 5'd7, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h80FF_0000, 5'd7, 0);
    idle(2, 5'd7);
    chk("lb_wd", last_wd, 32'hFFFF_FF80);
    step(0, 0, 0, 0, 1, 5'd8, 3'b101, 2'd2, 0, 0, 5'd8, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h80FF_0000, 5'd8, 0);
    idle(2, 5'd8);
    chk("lhu_wd", last_wd, 32'h0000_80FF);

    // Load completion racing two queued ALU results.
    wr_log.delete();
    step(0, 0, 0, 0, 1, 5'd10, 3'b010, 2'd0, 0, 0, 0, 0);
    step(0, 1, 5'd11, 32'hAAAA_0011, 0, 0, 0, 0, 0, 0, 5'd11, 0);
    step(0, 1, 5'd12, 32'hBBBB_0012, 0, 0, 0, 0, 1, 32'hCAFE_F00D, 5'd12, 5'd10);
    idle(4, 5'd12);
`ifdef RF_WB_ALU_BYPASS_EN
    exp_order = '{5'd11, 5'd10, 5'd12};
`else
    exp_order = '{5'd10, 5'd11, 5'd12};
`endif
    chk("order_cnt", wr_log.size(), 3);
    for (int i = 0; i < 3 && i < wr_log.size(); i++) chk("order_rd", 32'(wr_log[i]), 32'(exp_order[i]));

    // rd = 0 is swallowed.
    wr_log.delete();
    step(0, 1, 5'd0, 32'hDEAD_BEEF, 0, 0, 0, 0, 0, 0, 0, 0);
    idle(3, 5'd0);
    chk("rd0_no_write", wr_log.size(), 0);

    // Hazard on an outstanding load; a second issue is ignored.
    step(0, 0, 0, 0, 1, 5'd9, 3'b010, 2'd0, 0, 0, 5'd9, 0);
    step(0, 0, 0, 0, 1, 5'd4, 3'b010, 2'd0, 0, 0, 5'd9, 5'd4);
    idle(2, 5'd9);
    step(0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h0000_0099, 5'd9, 0);
    idle(3, 5'd9);

    // Reset while a load is pending and the FIFO is occupied.
    step(0, 0, 0, 0, 1, 5'd14, 3'b000, 2'd1, 0, 0, 0, 0);
    step(0, 1, 5'd13, 32'h1313_1313, 0, 0, 0, 0, 0, 0, 5'd13, 0);
    step(0, 1, 5'd15, 32'h1515_1515, 0, 0, 0, 0, 1, 32'h0000_8E00, 5'd15, 0);
    step(0, 0, 0, 0, 1, 5'd16, 3'b010, 2'd0, 0, 0, 5'd16, 5'd15);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 5'd16, 5'd15);
    reset_checks();
    wr_log.delete();
    step(0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h1616_1616, 5'd16, 0);
    idle(3, 5'd16);
    chk("stale_rvalid_no_write", wr_log.size(), 0);

    // Randomized traffic with occasional resets.
    for (int k = 0; k < 1500; k++) begin
      bit r, av, li, mv;
      logic [4:0] ard, lrd;
      r   = ($urandom_range(0, 199) == 0);
      av  = 1'($urandom_range(0, 1));
      ard = 5'($urandom_range(0, 7));
      li  = ($urandom_range(0, 3) == 0);
      lrd = 5'($urandom_range(0, 7));
      mv  = ($urandom_range(0, 2) == 0);
      if (busy(ard)) av = 1'b0;
      if (busy(lrd)) li = 1'b0;
      if (li && av && ard == lrd) av = 1'b0;
      step(r, av, ard, $urandom, li, lrd, 3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)),
           mv, $urandom, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
    end
    idle(6, 5'd0);
    chk("drain", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
